uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_tx byte transmitter between N byte-stream requesters (adder result echo, debug/status sources, etc.).
- Accepts bytes on per-requester valid/ready/last handshakes and issues single-cycle start pulses to the transmitter.
- Tracks transmitter activity so only one byte is in flight at a time.
- Sits between the requesters and the uart_tx instance, replacing its direct start/data connection.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ACT_TIMEOUT, 4, max cycles after tx_start to wait for tx_active to rise before declaring a fault.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N_REQ  per-requester byte valid
- req_data  input  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i]
- req_last  input  N_REQ  marks the final byte of a packet
- req_ready  output  N_REQ  combinational accept; byte transfers on the clock edge where valid&ready
- tx_start  output  1  one-cycle start pulse to transmitter (drives i_data_available)
- tx_data  output  8  byte to transmit; stable from start pulse until next accept
- tx_active  input  1  transmitter busy (o_active)
- grant_id  output  clog2(N_REQ)  index of current/last granted requester
- busy  output  1  high whenever state != IDLE
- err_timeout  output  1  one-cycle pulse when tx_active fails to rise

Behaviour:
- Reset values: all outputs 0, rr_ptr=0, state IDLE. Reset mid-transfer aborts everything; no byte is re-issued after reset.
- States: IDLE, HOLD, START, WAIT_ACT, WAIT_DONE.
- Arbitration (IDLE only):
  - Winner is the first set req_valid scanning from rr_ptr upward, wrapping modulo N_REQ.
  - req_ready[winner]=1 combinationally in that cycle; all other ready bits are 0.
  - At the edge: tx_data<=byte, grant_id<=winner, last_q<=req_last[winner], state->START.
- START: tx_start=1 for exactly this cycle -> WAIT_ACT. Latency from accept edge to tx_start high is 1 cycle.
- WAIT_ACT:
  - tx_active=1 -> WAIT_DONE.
  - Timeout counter reaching ACT_TIMEOUT -> pulse err_timeout, treat the byte as sent, take the end-of-byte path below.
- WAIT_DONE: on tx_active=0 (falling), end of byte:
  - Packet ends (last_q=1): rr_ptr<=grant_id+1 mod N_REQ, state->IDLE.
  - Otherwise: HOLD.
- HOLD:
  - Only requester grant_id may be accepted (req_ready[grant_id]=req_valid[grant_id]). Same capture rules as IDLE, -> START.
  - Other requesters' valids are ignored; waits indefinitely.
- req_ready is never asserted in START, WAIT_ACT or WAIT_DONE. Requesters must hold valid/data until accepted.
- Simultaneous valids: lowest index at or above rr_ptr wins. After a packet from requester k, requester k has lowest priority.
- No bytes are dropped or duplicated; byte order within a packet is preserved.
- tx_data is held after the byte completes (not cleared).

Optional Feature:
- Macro: UART_TX_ARB_PKT_LOCK_EN.
- Defined: packet lock as above; the HOLD state exists and req_last controls grant release.
- Undefined:
  - req_last is ignored and the HOLD state is removed.
  - Every byte ends with rr_ptr<=grant_id+1 and a return to IDLE, giving per-byte round-robin interleaving.

Test Plan:
- Single byte: req_valid=001, data0=0x5A, last=1 -> req_ready=001 for 1 cycle, tx_start 1 cycle later with tx_data=0x5A; after model tx_active high 10 cycles then low, busy drops, rr_ptr=1.
- Contention, lock enabled: req0 sends packet {0x01,0x02 last}, req2 valid with 0xC3 throughout -> tx order 0x01,0x02,0xC3; req2 ready never high while req0's packet is open.
- Contention, lock disabled: req0 {0x01,0x02}, req1 {0x11,0x12}, all valid -> tx order 0x01,0x11,0x02,0x12.
- Round-robin fairness: all three always valid, single-byte packets, 9 bytes -> grant_id sequence 0,1,2,0,1,2,0,1,2.
- Timeout: tx_active tied 0 -> err_timeout pulses exactly ACT_TIMEOUT cycles after tx_start; arbiter returns to IDLE and serves the next requester.
- Reset mid-byte: assert rst_n=0 during WAIT_DONE of 0x7E -> all outputs 0 immediately; after release, no tx_start until a new req_valid.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter in front of a single uart_tx
// Optional packet lock (HOLD state, req_last honoured) via UART_TX_ARB_PKT_LOCK_EN.
module uart_tx_arbiter #(
  parameter int N_REQ       = 3,
  parameter int ACT_TIMEOUT = 4,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_active,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               err_timeout
);

  localparam int CW = (ACT_TIMEOUT > 1) ? $clog2(ACT_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACT,
    S_WAIT_DONE
`ifdef UART_TX_ARB_PKT_LOCK_EN
    , S_HOLD
`endif
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant;
  logic [7:0]      r_tx_data;
  logic            r_tx_start;
  logic            r_err;
  logic [CW-1:0]   r_cnt;
`ifdef UART_TX_ARB_PKT_LOCK_EN
  logic            r_last_q;
`else
  logic            w_unused_last;
  assign w_unused_last = ^req_last;
`endif

  logic            w_found;
  logic [GW-1:0]   w_win;
  logic [GW:0]     w_sum;
  logic [GW-1:0]   w_sel;
  logic [N_REQ-1:0] w_ready;
  logic            w_accept;
  logic            w_timeout;
  logic            w_byte_done;
  logic [GW-1:0]   w_next_ptr;

  // First valid requester at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (GW+1)'(i);
      if (w_sum >= (GW+1)'(N_REQ)) w_sum = w_sum - (GW+1)'(N_REQ);
      if (!w_found && req_valid[w_sum[GW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    w_sel   = w_win;
    if (r_state == S_IDLE) begin
      if (w_found) w_ready[w_win] = 1'b1;
    end
`ifdef UART_TX_ARB_PKT_LOCK_EN
    else if (r_state == S_HOLD) begin
      w_sel            = r_grant;
      w_ready[r_grant] = req_valid[r_grant];
    end
`endif
  end

  assign req_ready   = rst_n ? w_ready : '0;
  assign w_accept    = |(req_valid & w_ready);
  assign w_timeout   = (r_state == S_WAIT_ACT) && !tx_active &&
                       (r_cnt >= CW'(ACT_TIMEOUT - 1));
  assign w_byte_done = w_timeout || ((r_state == S_WAIT_DONE) && !tx_active);
  assign w_next_ptr  = (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + GW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
      r_last_q   <= 1'b0;
`endif
    end else begin
      r_tx_start <= 1'b0;
      r_err      <= w_timeout;
      case (r_state)
        S_START: begin
          r_cnt   <= CW'(1);
          r_state <= S_WAIT_ACT;
        end
        S_WAIT_ACT: begin
          if (tx_active) r_state <= S_WAIT_DONE;
          else if (!w_timeout) r_cnt <= r_cnt + CW'(1);
        end
        S_WAIT_DONE: ;
        default: begin
          if (w_accept) begin
            r_tx_data  <= req_data[{w_sel, 3'b000} +: 8];
            r_grant    <= w_sel;
            r_tx_start <= 1'b1;
            r_state    <= S_START;
`ifdef UART_TX_ARB_PKT_LOCK_EN
            r_last_q   <= req_last[w_sel];
`endif
          end
        end
      endcase
      // A timed-out byte is treated exactly like a completed one.
      if (w_byte_done) begin
`ifdef UART_TX_ARB_PKT_LOCK_EN
        if (r_last_q) begin
          r_rr_ptr <= w_next_ptr;
          r_state  <= S_IDLE;
        end else begin
          r_state  <= S_HOLD;
        end
`else
        r_rr_ptr <= w_next_ptr;
        r_state  <= S_IDLE;
`endif
      end
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant;
  assign err_timeout = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule
